// File: rtl/l1_miss_request_unit_pkg.sv
// Shared definitions for the L1 miss request unit: command encodings,
// FSM state encoding and the log2 helper used to size the block offset.
package l1_miss_request_unit_pkg;

   localparam logic [2:0] CACHE_REQUEST_READIN_BLOCK   = 3'd1;
   localparam logic [2:0] CACHE_REQUEST_WRITEOUT_BLOCK = 3'd2;
   localparam logic [2:0] CACHE_SERVICE_READIN_BLOCK   = 3'd3;

   typedef enum logic [2:0] {
      IDLE,
      SEND_WB,
      SEND_RD,
      WAIT_FILL,
      DELIVER
   } miss_state_t;

   function automatic int CLOG2(input int value);
      return $clog2(value);
   endfunction

endpackage

// File: rtl/l1_miss_request_unit.sv
// Single-outstanding-miss engine between an L1 cache and the next-level
// controller: optional victim writeback, block read, fill handback.
module l1_miss_request_unit
   import l1_miss_request_unit_pkg::*;
#(
   parameter int BW_USED_ADDR_WORD     = 24,
   parameter int BW_DATA_EXTERNAL_BUS  = 512,
   parameter int BW_CACHE_COMMAND      = 3,
   parameter int CACHE_WORDS_PER_BLOCK = 16,
   parameter int TIMEOUT_CYCLES        = 4096,
   parameter int BW_WORDS_PER_BLOCK    = CLOG2(CACHE_WORDS_PER_BLOCK)
)(
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            miss_valid_i,
   output logic                            miss_ready_o,
   input  logic [BW_USED_ADDR_WORD-1:0]    miss_addr_i,
   input  logic                            victim_dirty_i,
   input  logic [BW_USED_ADDR_WORD-1:0]    victim_addr_i,
   input  logic [BW_DATA_EXTERNAL_BUS-1:0] victim_data_i,
   output logic                            req_write_o,
   output logic [BW_CACHE_COMMAND-1:0]     req_command_o,
   output logic [BW_USED_ADDR_WORD-1:0]    req_addr_o,
   output logic [BW_DATA_EXTERNAL_BUS-1:0] req_data_o,
   input  logic                            req_full_i,
   input  logic                            rsp_write_i,
   input  logic [BW_CACHE_COMMAND-1:0]     rsp_command_i,
   input  logic [BW_USED_ADDR_WORD-1:0]    rsp_addr_i,
   input  logic [BW_DATA_EXTERNAL_BUS-1:0] rsp_data_i,
   output logic                            rsp_full_o,
   output logic                            fill_valid_o,
   input  logic                            fill_ready_i,
   output logic [BW_USED_ADDR_WORD-1:0]    fill_addr_o,
   output logic [BW_DATA_EXTERNAL_BUS-1:0] fill_data_o,
   output logic                            err_unexpected_o,
   output logic                            err_timeout_o,
   output logic [31:0]                     miss_count_o
);

   localparam logic [BW_USED_ADDR_WORD-1:0] ALIGN_MASK =
      {{(BW_USED_ADDR_WORD-BW_WORDS_PER_BLOCK){1'b1}}, {BW_WORDS_PER_BLOCK{1'b0}}};
   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   miss_state_t                      state, state_next;
   logic [BW_USED_ADDR_WORD-1:0]     miss_addr_q;
   logic [BW_USED_ADDR_WORD-1:0]     victim_addr_q;
   logic [BW_DATA_EXTERNAL_BUS-1:0]  victim_data_q;
   logic [31:0]                      timeout_count_q;
   logic                             accept;
   logic                             rsp_match;

   assign miss_ready_o = (state == IDLE);
   assign accept       = miss_valid_i && miss_ready_o;
   assign rsp_match    = rsp_write_i
                         && (rsp_command_i == BW_CACHE_COMMAND'(CACHE_SERVICE_READIN_BLOCK))
                         && ((rsp_addr_i & ALIGN_MASK) == miss_addr_q);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (accept)        state_next = victim_dirty_i ? SEND_WB : SEND_RD;
         SEND_WB:   if (!req_full_i)   state_next = SEND_RD;
         SEND_RD:   if (!req_full_i)   state_next = WAIT_FILL;
         WAIT_FILL: if (rsp_match)     state_next = DELIVER;
         DELIVER:   if (fill_ready_i)  state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_next;
   end

   // Datapath and registered outputs; pushes are single-cycle pulses that
   // fire only on the edge where the controller buffer reports space.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         miss_addr_q      <= '0;
         victim_addr_q    <= '0;
         victim_data_q    <= '0;
         timeout_count_q  <= '0;
         req_write_o      <= 1'b0;
         req_command_o    <= '0;
         req_addr_o       <= '0;
         req_data_o       <= '0;
         rsp_full_o       <= 1'b1;
         fill_valid_o     <= 1'b0;
         fill_addr_o      <= '0;
         fill_data_o      <= '0;
         err_unexpected_o <= 1'b0;
         err_timeout_o    <= 1'b0;
         miss_count_o     <= '0;
      end else begin
         req_write_o <= 1'b0;
         rsp_full_o  <= (state_next != WAIT_FILL);
         case (state)
            IDLE: begin
               if (accept) begin
                  miss_addr_q   <= miss_addr_i & ALIGN_MASK;
                  victim_addr_q <= victim_addr_i & ALIGN_MASK;
                  victim_data_q <= victim_data_i;
                  miss_count_o  <= miss_count_o + 32'd1;
               end
            end
            SEND_WB: begin
               if (!req_full_i) begin
                  req_write_o   <= 1'b1;
                  req_command_o <= BW_CACHE_COMMAND'(CACHE_REQUEST_WRITEOUT_BLOCK);
                  req_addr_o    <= victim_addr_q;
                  req_data_o    <= victim_data_q;
               end
            end
            SEND_RD: begin
               timeout_count_q <= '0;
               if (!req_full_i) begin
                  req_write_o   <= 1'b1;
                  req_command_o <= BW_CACHE_COMMAND'(CACHE_REQUEST_READIN_BLOCK);
                  req_addr_o    <= miss_addr_q;
                  req_data_o    <= '0;
               end
            end
            WAIT_FILL: begin
               // Counter saturates at the limit so the flag stays meaningful.
               if (timeout_count_q != TIMEOUT_LIMIT) begin
                  timeout_count_q <= timeout_count_q + 32'd1;
                  if (timeout_count_q == TIMEOUT_LIMIT - 32'd1) err_timeout_o <= 1'b1;
               end
               if (rsp_match) begin
                  fill_valid_o <= 1'b1;
                  fill_addr_o  <= miss_addr_q;
                  fill_data_o  <= rsp_data_i;
               end else if (rsp_write_i) begin
                  err_unexpected_o <= 1'b1;
               end
            end
            DELIVER: begin
               if (fill_ready_i) fill_valid_o <= 1'b0;
            end
            default: ;
         endcase
         if (rsp_write_i && (state != WAIT_FILL)) err_unexpected_o <= 1'b1;
      end
   end

endmodule
